// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline types: fetch-stage FSM states and instruction width
package mips_pkg;

  localparam int INSN_W = 32;

  typedef enum logic [2:0] {
    IFS_BOOT  = 3'd0,
    IFS_RUN   = 3'd1,
    IFS_STALL = 3'd2,
    IFS_FLUSH = 3'd3,
    IFS_HALT  = 3'd4
  } ifs_state_e;

endpackage

// File: rtl/pc_target_check.sv
// rtl/pc_target_check.sv - flags a 32-bit byte address as a legal word fetch address
module pc_target_check #(
  parameter int ADDR_W    = 8,
  parameter int MEM_BYTES = 150
) (
  input  logic [31:0] target_i,
  output logic        legal_o
);

  localparam logic [31:0] MAX_PC = 32'(MEM_BYTES - 4);

  // The upper-bit test matters only for redirect targets; a sequential PC never reaches it.
  assign legal_o = (target_i[1:0] == 2'b00) &&
                   (target_i <= MAX_PC) &&
                   ((target_i >> ADDR_W) == 32'd0);

endmodule

// File: rtl/if_pc_sequencer.sv
// rtl/if_pc_sequencer.sv - IF-stage PC register with stall, redirect, wrap and halt sequencing
module if_pc_sequencer
  import mips_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int          MEM_BYTES = 150,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [31:0]       redirect_pc_i,
  input  logic              halt_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [31:0]       pc_plus4_o,
  output logic              fetch_valid_o,
  output logic              flush_o,
  output logic              wrap_o,
  output logic              fault_o,
  output logic [2:0]        state_o
);

  localparam logic [ADDR_W-1:0] RESET_PC_A = ADDR_W'(RESET_PC);

  ifs_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              flush_q, flush_d;
  logic              wrap_q, wrap_d;
  logic              fault_q, fault_d;

  logic [31:0] seq_pc;
  logic        seq_legal;
  logic        redir_legal;

  assign seq_pc = {{(32-ADDR_W){1'b0}}, pc_q} + 32'd4;

  pc_target_check #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) u_seq_check (
    .target_i (seq_pc),
    .legal_o  (seq_legal)
  );

  pc_target_check #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) u_redir_check (
    .target_i (redirect_pc_i),
    .legal_o  (redir_legal)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wrap_d  = 1'b0;
    fault_d = fault_q;
    case (state_q)
      IFS_BOOT: begin
        state_d = IFS_RUN;
        pc_d    = RESET_PC_A;
      end
      IFS_RUN, IFS_STALL: begin
        if (halt_i) begin
          state_d = IFS_HALT;
        end else if (redirect_i) begin
          if (redir_legal) begin
            pc_d    = redirect_pc_i[ADDR_W-1:0];
            state_d = IFS_FLUSH;
          end else begin
            fault_d = 1'b1;
            state_d = IFS_HALT;
          end
        end else if (stall_i) begin
          state_d = IFS_STALL;
        end else begin
          state_d = IFS_RUN;
          if (seq_legal) begin
            pc_d = seq_pc[ADDR_W-1:0];
          end else begin
            pc_d   = RESET_PC_A;
            wrap_d = 1'b1;
          end
        end
      end
      // The redirect target already sits in the PC; it is fetched in the following RUN cycle.
      IFS_FLUSH: begin
        if (halt_i) begin
          state_d = IFS_HALT;
        end else begin
          state_d = stall_i ? IFS_STALL : IFS_RUN;
        end
      end
      IFS_HALT: state_d = IFS_HALT;
      default:  state_d = IFS_BOOT;
    endcase
    fetch_valid_d = (state_d == IFS_RUN) || (state_d == IFS_STALL);
    flush_d       = (state_d == IFS_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IFS_BOOT;
      pc_q          <= RESET_PC_A;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      wrap_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      wrap_q        <= wrap_d;
      fault_q       <= fault_d;
    end
  end

  assign pc_o          = pc_q;
  assign pc_plus4_o    = seq_pc;
  assign fetch_valid_o = fetch_valid_q;
  assign flush_o       = flush_q;
  assign wrap_o        = wrap_q;
  assign fault_o       = fault_q;
  assign state_o       = state_q;

endmodule
